// File: rtl/bsg_strobe_multi.sv
// bsg_strobe_multi
//
// Multi-channel programmable strobe generator. Every channel counts down
// from a programmable phase, emits a one-cycle registered pulse when the
// count reaches zero, and reloads its period so that the pulse repeats
// every period+1 enabled cycles. A one-shot channel disarms itself after
// its pulse and is re-armed by the global sync pulse, which also restarts
// every configured channel from its phase.
//
// Ports:
//   clk_i          clock, all state updates on posedge
//   reset_n_i      asynchronous active-low reset, clears all state
//   cfg_v_i        config write valid (single cycle)
//   cfg_chan_i     channel targeted by the config write
//   cfg_period_i   period P, strobe interval is P+1 enabled cycles
//   cfg_phase_i    initial countdown value (first strobe after phase+1)
//   cfg_oneshot_i  1 = one-shot, 0 = periodic
//   en_i           per-channel count enable (level)
//   sync_i         global realign pulse
//   strobe_r_o     registered strobe per channel
//   armed_r_o      registered armed flag per channel
//
// Config interface: cfg_v_i qualifies cfg_chan_i/cfg_period_i/cfg_phase_i/
// cfg_oneshot_i for exactly the cycle it is high. There is no ready: every
// valid write is consumed on the next posedge. A write whose channel index
// does not name an existing channel matches no channel and is dropped.

module bsg_strobe_multi #(
  parameter int width_p    = 8,
  parameter int channels_p = 4,
  localparam int chan_id_width_lp = (channels_p > 1) ? $clog2(channels_p) : 1
) (
  input  logic                        clk_i,
  input  logic                        reset_n_i,
  input  logic                        cfg_v_i,
  input  logic [chan_id_width_lp-1:0] cfg_chan_i,
  input  logic [width_p-1:0]          cfg_period_i,
  input  logic [width_p-1:0]          cfg_phase_i,
  input  logic                        cfg_oneshot_i,
  input  logic [channels_p-1:0]       en_i,
  input  logic                        sync_i,
  output logic [channels_p-1:0]       strobe_r_o,
  output logic [channels_p-1:0]       armed_r_o
);

  // Per-channel registered state
  logic [width_p-1:0]    period_r [channels_p];
  logic [width_p-1:0]    phase_r  [channels_p];
  logic [width_p-1:0]    cnt_r    [channels_p];
  logic [channels_p-1:0] oneshot_r;
  logic [channels_p-1:0] armed_r;
  logic [channels_p-1:0] strobe_r;

  // Next-state values
  logic [width_p-1:0]    period_n [channels_p];
  logic [width_p-1:0]    phase_n  [channels_p];
  logic [width_p-1:0]    cnt_n    [channels_p];
  logic [channels_p-1:0] oneshot_n;
  logic [channels_p-1:0] armed_n;
  logic [channels_p-1:0] strobe_n;

  // One-hot decode of the config target. An out-of-range index (possible
  // when channels_p is not a power of two) produces no hit at all.
  logic [channels_p-1:0] cfg_hit;

  always_comb begin
    cfg_hit = '0;
    for (int c = 0; c < channels_p; c++) begin
      cfg_hit[c] = cfg_v_i && (int'(cfg_chan_i) == c);
    end
  end

  // Per-channel update, priority: config > sync > count > hold.
  always_comb begin
    oneshot_n = oneshot_r;
    armed_n   = armed_r;
    strobe_n  = '0;
    for (int c = 0; c < channels_p; c++) begin
      period_n[c] = period_r[c];
      phase_n[c]  = phase_r[c];
      cnt_n[c]    = cnt_r[c];

      if (cfg_hit[c]) begin
        // Config wins over sync and ignores this cycle's enable.
        period_n[c]  = cfg_period_i;
        phase_n[c]   = cfg_phase_i;
        cnt_n[c]     = cfg_phase_i;
        oneshot_n[c] = cfg_oneshot_i;
        armed_n[c]   = 1'b1;
      end else if (sync_i && (armed_r[c] || oneshot_r[c])) begin
        // Restart from the phase. A spent one-shot still has oneshot_r set,
        // which is what lets sync re-arm it; never-configured channels have
        // both flags clear and are left alone.
        cnt_n[c]   = phase_r[c];
        armed_n[c] = 1'b1;
      end else if (armed_r[c] && en_i[c]) begin
        if (cnt_r[c] == '0) begin
          // Reload at zero, so the decrement below can never wrap.
          strobe_n[c] = 1'b1;
          cnt_n[c]    = period_r[c];
          if (oneshot_r[c]) begin
            armed_n[c] = 1'b0;
          end
        end else begin
          cnt_n[c] = cnt_r[c] - width_p'(1);
        end
      end
      // Otherwise disarmed or disabled: the count freezes, strobe stays low.
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      oneshot_r <= '0;
      armed_r   <= '0;
      strobe_r  <= '0;
      for (int c = 0; c < channels_p; c++) begin
        period_r[c] <= '0;
        phase_r[c]  <= '0;
        cnt_r[c]    <= '0;
      end
    end else begin
      oneshot_r <= oneshot_n;
      armed_r   <= armed_n;
      strobe_r  <= strobe_n;
      for (int c = 0; c < channels_p; c++) begin
        period_r[c] <= period_n[c];
        phase_r[c]  <= phase_n[c];
        cnt_r[c]    <= cnt_n[c];
      end
    end
  end

  // Outputs come straight from flops.
  assign strobe_r_o = strobe_r;
  assign armed_r_o  = armed_r;

endmodule
